// File: rtl/program_memory_loader.sv
// Boot-time program memory writer: packs a big-endian byte stream into 32-bit
// instructions and writes them to consecutive word-aligned addresses from 0.
module program_memory_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] WordCount,
    input  logic [7:0]            ByteData,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done
);

    localparam int CW = $clog2(MEMORY_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           index_q, index_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    write_enable_q, write_enable_d;
    logic [DATA_WIDTH-1:0]   write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CW-1:0]           clamped_count;
    logic [DATA_WIDTH-1:0]   next_word;

    // Requests larger than the memory are clamped so the loader never writes past its end.
    assign clamped_count = (WordCount > DATA_WIDTH'(MEMORY_DEPTH)) ? CW'(MEMORY_DEPTH)
                                                                  : WordCount[CW-1:0];
    assign next_word     = {word_q[DATA_WIDTH-9:0], ByteData};

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        index_d         = index_q;
        byte_cnt_d      = byte_cnt_q;
        word_d          = word_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    count_d    = clamped_count;
                    index_d    = '0;
                    byte_cnt_d = '0;
                    state_d    = (clamped_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (ByteValid) begin
                    word_d     = next_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // The write strobe and its address/data are registered alongside the move to WRITE.
                    if (byte_cnt_q == 2'd3) begin
                        state_d         = WRITE;
                        write_enable_d  = 1'b1;
                        write_address_d = DATA_WIDTH'({index_q, 2'b00});
                        write_data_d    = next_word;
                    end
                end
            end
            WRITE: begin
                index_d = index_q + 1'b1;
                state_d = (index_d == count_q) ? DONE : LOAD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            count_q         <= '0;
            index_q         <= '0;
            byte_cnt_q      <= '0;
            word_q          <= '0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            index_q         <= index_d;
            byte_cnt_q      <= byte_cnt_d;
            word_q          <= word_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign ByteReady    = (state_q == LOAD);
    assign WriteEnable  = write_enable_q;
    assign WriteAddress = write_address_q;
    assign WriteData    = write_data_q;
    assign Busy         = busy_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: random byte streams and stalls, compared
// against word lists computed directly from the stream bytes.
module tb_program_memory_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [31:0] WordCount;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_memory_loader #(
        .MEMORY_DEPTH(DEPTH),
        .DATA_WIDTH  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .WordCount   (WordCount),
        .ByteData    (ByteData),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .Busy        (Busy),
        .Done        (Done)
    );

    // Every observed write strobe and Done pulse is logged with its cycle number.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          we_cycles[$];
    int          done_cycles[$];
    int          overlap = 0;

    always @(negedge clk) begin
        if (WriteEnable) begin
            wr_addr_q.push_back(WriteAddress);
            wr_data_q.push_back(WriteData);
            we_cycles.push_back(cyc);
            if (ByteReady) overlap = overlap + 1;
        end
        if (Done) done_cycles.push_back(cyc);
    end

    logic [7:0] stream[$];
    bit         use_fixed;
    int         wr_mark, done_mark, overlap_mark;
    int         accepted, start_cycle, first_ready_cycle, first_accept_cycle;
    int         busy_bad, post_bad;
    bit         timed_out;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expectedWord(input int w);
        return 32'(stream[4*w]) * 32'd16777216 + 32'(stream[4*w+1]) * 32'd65536
             + 32'(stream[4*w+2]) * 32'd256 + 32'(stream[4*w+3]);
    endfunction

    task automatic applyStimulus(input int wc, input int n_offer, input int valid_pct,
                                 input int busy_start_at, input int reset_at);
        int post;
        bit finished;
        bit start_pulsed;
        stream.delete();
        for (int i = 0; i < n_offer; i++) stream.push_back(8'($urandom));
        if (use_fixed) begin
            stream[0] = 8'h20;
            stream[1] = 8'h08;
            stream[2] = 8'h00;
            stream[3] = 8'h05;
        end
        wr_mark            = wr_addr_q.size();
        done_mark          = done_cycles.size();
        overlap_mark       = overlap;
        accepted           = 0;
        first_ready_cycle  = -1;
        first_accept_cycle = -1;
        busy_bad           = 0;
        post_bad           = 0;
        timed_out          = 1'b0;

        @(posedge clk); #1;
        Start       = 1'b1;
        WordCount   = 32'(wc);
        ByteValid   = 1'b0;
        start_cycle = cyc;
        @(posedge clk); #1;
        Start     = 1'b0;
        WordCount = $urandom;

        finished     = 1'b0;
        post         = 0;
        start_pulsed = 1'b0;
        for (int k = 0; k < 4000 && !finished; k++) begin
            ByteValid = (accepted < n_offer) && ($urandom_range(0, 99) < valid_pct);
            ByteData  = (accepted < n_offer) ? stream[accepted] : 8'($urandom);
            if (busy_start_at >= 0 && !start_pulsed && accepted == busy_start_at) begin
                Start        = 1'b1;
                WordCount    = 32'd5;
                start_pulsed = 1'b1;
            end
            if (reset_at >= 0 && accepted == reset_at) reset = 1'b1;
            @(negedge clk);
            if (ByteReady && first_ready_cycle < 0) first_ready_cycle = cyc;
            if (ByteValid && ByteReady && !reset) begin
                if (first_accept_cycle < 0) first_accept_cycle = cyc;
                accepted++;
            end
            if (post == 0 && !Busy) busy_bad++;
            if (post > 0 && (Busy || ByteReady || WriteEnable || Done)) post_bad++;
            if (reset) finished = 1'b1;
            else if (post > 0 || Done) post++;
            if (post > 6) finished = 1'b1;
            @(posedge clk); #1;
            Start = 1'b0;
            reset = 1'b0;
        end
        ByteValid = 1'b0;
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic verifyLoad(input string name, input int n_words, input int n_accepted, input int n_done);
        checkOutput({name, " timeout"}, 32'(timed_out), 32'd0);
        checkOutput({name, " write count"}, 32'(wr_addr_q.size() - wr_mark), 32'(n_words));
        for (int i = 0; i < n_words && wr_mark + i < wr_addr_q.size(); i++) begin
            checkOutput({name, " addr"}, wr_addr_q[wr_mark + i], 32'(4 * i));
            checkOutput({name, " data"}, wr_data_q[wr_mark + i], expectedWord(i));
        end
        checkOutput({name, " accepted bytes"}, 32'(accepted), 32'(n_accepted));
        checkOutput({name, " done pulses"}, 32'(done_cycles.size() - done_mark), 32'(n_done));
        checkOutput({name, " ready during write"}, 32'(overlap - overlap_mark), 32'd0);
        checkOutput({name, " busy gaps"}, 32'(busy_bad), 32'd0);
        checkOutput({name, " activity after done"}, 32'(post_bad), 32'd0);
    endtask

    initial begin
        int mark;
        reset     = 1'b1;
        Start     = 1'b0;
        WordCount = '0;
        ByteData  = '0;
        ByteValid = 1'b0;
        use_fixed = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ByteReady", 32'(ByteReady), 32'd0);
        checkOutput("reset WriteEnable", 32'(WriteEnable), 32'd0);
        checkOutput("reset WriteAddress", WriteAddress, 32'd0);
        checkOutput("reset WriteData", WriteData, 32'd0);
        checkOutput("reset Busy", 32'(Busy), 32'd0);
        checkOutput("reset Done", 32'(Done), 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        ByteValid = 1'b1;
        mark      = wr_addr_q.size();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("idle valid writes", 32'(wr_addr_q.size() - mark), 32'd0);
        checkOutput("idle ByteReady", 32'(ByteReady), 32'd0);
        @(posedge clk); #1;
        ByteValid = 1'b0;

        $display("[TB] single word");
        use_fixed = 1'b1;
        applyStimulus(1, 4, 100, -1, -1);
        use_fixed = 1'b0;
        verifyLoad("single", 1, 4, 1);
        checkOutput("single start to ready", 32'(first_ready_cycle - start_cycle), 32'd1);
        checkOutput("single data literal", (wr_data_q.size() > wr_mark) ? wr_data_q[wr_mark] : 32'hx, 32'h20080005);
        if (we_cycles.size() > wr_mark && done_cycles.size() > done_mark) begin
            checkOutput("single accept to write", 32'(we_cycles[wr_mark] - first_accept_cycle), 32'd4);
            checkOutput("single write to done", 32'(done_cycles[done_mark] - we_cycles[wr_mark]), 32'd1);
        end

        $display("[TB] three words with stalls");
        applyStimulus(3, 12, 50, -1, -1);
        verifyLoad("stall3", 3, 12, 1);

        $display("[TB] random loads");
        for (int r = 0; r < 3; r++) begin
            int wc;
            wc = $urandom_range(1, 6);
            applyStimulus(wc, 4 * wc + 4, $urandom_range(40, 100), -1, -1);
            verifyLoad("random", wc, 4 * wc, 1);
        end

        $display("[TB] clamped count");
        applyStimulus(40, 160, 85, -1, -1);
        verifyLoad("clamp", DEPTH, 4 * DEPTH, 1);
        checkOutput("clamp last addr",
                    (wr_addr_q.size() > 0) ? wr_addr_q[wr_addr_q.size() - 1] : 32'hx, 32'h7C);

        $display("[TB] zero count");
        applyStimulus(0, 4, 100, -1, -1);
        verifyLoad("zero", 0, 0, 1);
        if (done_cycles.size() > done_mark)
            checkOutput("zero start to done", 32'(done_cycles[done_mark] - start_cycle), 32'd1);

        $display("[TB] reset mid-word");
        applyStimulus(2, 8, 100, -1, 6);
        verifyLoad("midreset", 1, 6, 0);
        @(negedge clk);
        checkOutput("midreset ByteReady", 32'(ByteReady), 32'd0);
        checkOutput("midreset Busy", 32'(Busy), 32'd0);
        checkOutput("midreset WriteEnable", 32'(WriteEnable), 32'd0);
        applyStimulus(2, 8, 70, -1, -1);
        verifyLoad("reload", 2, 8, 1);

        $display("[TB] start while busy");
        applyStimulus(2, 20, 100, 2, -1);
        verifyLoad("busystart", 2, 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

Boot-time writer for the instruction memory. It receives the program as a big-endian byte stream over a valid/ready handshake, packs every four bytes into one 32-bit instruction, and issues one write per word at word-aligned byte addresses 0, 4, 8, … This is the write side of the asynchronous-read program memory. It drives a RAM-backed program memory's write port, and its `Busy` output holds the CPU in reset while loading.

## Interface
- `MEMORY_DEPTH`, default 32: number of instruction words in the target memory; upper bound on words written.
- `DATA_WIDTH`, default 32: instruction and address width. Must be 32.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `Start`  input  1: one-cycle request to begin a load. Sampled only in IDLE.
- `WordCount`  input  DATA_WIDTH: number of words to load. Latched when `Start` is accepted.
- `ByteData`  input  8: stream byte.
- `ByteValid`  input  1: `ByteData` is valid.
- `ByteReady`  output  1: loader accepts a byte this cycle.
- `WriteEnable`  output  1: one-cycle write strobe to program memory.
- `WriteAddress`  output  DATA_WIDTH: byte address; always a multiple of 4.
- `WriteData`  output  DATA_WIDTH: assembled instruction.
- `Busy`  output  1: load in progress (CPU hold).
- `Done`  output  1: one-cycle pulse when the load completes.

## Operation
- **States:**
  - IDLE
  - LOAD: accepting bytes.
  - WRITE: strobe a word.
  - DONE
- **Byte transfer:** a byte is transferred when `ByteValid && ByteReady` at a rising edge.
- **Ready:** `ByteReady` = 1 only in LOAD. It is combinational from state and does not depend on `ByteValid`.
- **Packing (big-endian):** the first byte of a word goes to bits [31:24], the second to [23:16], the third to [15:8] and the fourth to [7:0].
  - Implementation is a shift register: `word <= {word[23:0], ByteData}`.
  - A 2-bit byte counter runs 0..3.
- **IDLE:**
  - `Start` = 1 latches `count = min(WordCount, MEMORY_DEPTH)` and clears the word index and byte counter.
  - If `count` = 0, go to DONE. Otherwise go to LOAD.
- **LOAD:**
  - On an accepted byte with byte counter = 3, go to WRITE. The counter wraps to 0.
  - Otherwise stay in LOAD.
- **WRITE:**
  - `WriteEnable` = 1.
  - `WriteAddress` = `{index, 2'b00}` zero-extended to DATA_WIDTH.
  - `WriteData` = assembled word.
  - Next cycle, the index increments. If `index+1` = `count`, go to DONE; else go to LOAD.
- **DONE:** `Done` = 1 for exactly one cycle, then IDLE.
- **Busy:** `Busy` = 1 in LOAD and WRITE. It is also 1 in DONE, so that `Done` and `Busy` deassert together into IDLE.
- **Start while busy:** `Start` outside IDLE is ignored and has no effect on count or index.
- **`ByteValid` outside LOAD:** ignored; no byte is consumed.
- **Write data:** `WriteAddress` and `WriteData` are registered and hold their last values outside WRITE. Consumers must qualify them with `WriteEnable`.
- **Overflow:** `WordCount > MEMORY_DEPTH` is clamped. Exactly `MEMORY_DEPTH` words are written and further stream bytes are not accepted.

## Timing
- **Reset values:**
  - state IDLE
  - `ByteReady` = 0
  - `WriteEnable` = 0
  - `WriteAddress` = 0
  - `WriteData` = 0
  - `Busy` = 0
  - `Done` = 0
  - count, index and byte counter all 0
- **Reset mid-load:** reset asserted in any state returns to IDLE on that edge. A partially assembled word is discarded and no `WriteEnable` is issued for it. Words already written are not undone.
- **Start to ready:** `Start` accepted at edge N → `ByteReady` = 1 in cycle N+1.
- **Byte to write:** fourth byte accepted at edge M → `WriteEnable` high during cycle M+1 (the memory captures at edge M+2) → `ByteReady` high again in cycle M+2.
- **Throughput:** with `ByteValid` held high, one word per 5 cycles: 4 accept cycles plus 1 WRITE cycle.
- **Done latency:** the last WRITE cycle is followed by DONE for 1 cycle (`Done` = 1), then IDLE.
  - For `WordCount` = 0, `Done` pulses in cycle N+1 after `Start` is accepted at edge N.
- **Stalls:** `ByteValid` low while in LOAD stalls indefinitely. No timeout.

## Test plan
- **Reset:** assert `reset` for 2 cycles → all outputs 0, `ByteReady` = 0. Drive `ByteValid` = 1 → no write occurs.
- **Single word:** `Start`, `WordCount` = 1, bytes 0x20,0x08,0x00,0x05 back-to-back → exactly one `WriteEnable` pulse with `WriteAddress` = 0x0, `WriteData` = 0x20080005 on the 5th cycle after the first accept. Then `Done` pulses once and `Busy` drops.
- **Three words with stalls:** `WordCount` = 3, random `ByteValid` gaps → writes at addresses 0x0, 0x4, 0x8 with the correct words, in order. `ByteReady` is never high in a WRITE cycle.
- **Clamping and zero count:**
  - `WordCount` = 40 with `MEMORY_DEPTH` = 32 → 32 writes, last at 0x7C, then `Done`. The 129th byte is never accepted.
  - `WordCount` = 0 → `Done` 1 cycle after `Start`, no write.
- **Reset mid-word:** after 2 bytes of word 1 (`WordCount` = 2), assert `reset` → no `WriteEnable` for word 1, state IDLE. A fresh `Start` reloads from address 0x0.
- **Start while busy:** pulse `Start` with `WordCount` = 5 mid-load of a 2-word transfer → exactly 2 writes, then `Done`.
